// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: instruction sequencer for the 18-bit core.
// It owns the PC and fetches each word over a req/ack handshake.
// It loads the word into the splitter, starts execute and waits for done.
// It then applies the PC update and any pending halt.
// Optional fetch watchdog: define FETCH_TIMEOUT_EN to enable the FETCH no-ack timeout
// and the sticky fault_o / terminal FAULT state.
module fetch_seq_ctrl #(
   parameter logic [11:0] RESET_PC    = 12'h000,
   parameter int          TIMEOUT_CYC = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        halt_i,
   output logic        imem_req_o,
   output logic [11:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [17:0] imem_data_i,
   output logic [17:0] inst_o,
   output logic        is_en_o,
   output logic        exec_start_o,
   input  logic        exec_done_i,
   input  logic        pc_load_i,
   input  logic [11:0] pc_target_i,
   output logic [11:0] pc_o,
   output logic        busy_o,
   output logic [15:0] retired_o,
   output logic        fault_o
);

   // state  | meaning
   // IDLE   | stopped; waits for start_i without halt_i
   // FETCH  | imem_req_o held at pc until imem_ack_i
   // DECODE | is_en_o pulse, splitter latches inst_o
   // EXEC   | exec_start_o on first cycle, waits for exec_done_i
   // FAULT  | fetch watchdog expired; terminal until reset
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t      state_q;
   logic [11:0] pc_q;
   logic [11:0] pc_d;
   logic [17:0] inst_q;
   logic [15:0] retired_q;
   logic        halt_pend_q;
   logic        req_q;
   logic        is_en_q;
   logic        exec_start_q;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] tmo_cnt_q;
   logic       fault_q;
`endif

   // Next PC applied when the current instruction retires
   always_comb begin
      pc_d = pc_q + 12'd1;
      if (pc_load_i) pc_d = pc_target_i;
   end

   // Sequencer FSM with registered handshake and pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= 18'h0;
         retired_q    <= 16'h0;
         halt_pend_q  <= 1'b0;
         req_q        <= 1'b0;
         is_en_q      <= 1'b0;
         exec_start_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q    <= 8'h0;
         fault_q      <= 1'b0;
`endif
      end else begin
         is_en_q      <= 1'b0;
         exec_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               halt_pend_q <= 1'b0;
               if (start_i && !halt_i) begin
                  state_q <= S_FETCH;
                  req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                  tmo_cnt_q <= 8'h0;
`endif
               end
            end
            S_FETCH: begin
               if (halt_i) halt_pend_q <= 1'b1;
               if (imem_ack_i) begin
                  inst_q  <= imem_data_i;
                  req_q   <= 1'b0;
                  is_en_q <= 1'b1;
                  state_q <= S_DECODE;
               end
`ifdef FETCH_TIMEOUT_EN
               // an ack in the last allowed cycle is taken above, so it beats the timeout
               else if (tmo_cnt_q == TMO_LAST) begin
                  fault_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= S_FAULT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
`endif
            end
            S_DECODE: begin
               if (halt_i) halt_pend_q <= 1'b1;
               exec_start_q <= 1'b1;
               state_q      <= S_EXEC;
            end
            S_EXEC: begin
               if (exec_done_i) begin
                  pc_q      <= pc_d;
                  retired_q <= retired_q + 16'd1;
                  if (halt_pend_q || halt_i) begin
                     halt_pend_q <= 1'b0;
                     state_q     <= S_IDLE;
                  end else begin
                     state_q <= S_FETCH;
                     req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                     tmo_cnt_q <= 8'h0;
`endif
                  end
               end else if (halt_i) begin
                  halt_pend_q <= 1'b1;
               end
            end
            S_FAULT: begin
               req_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = pc_q;
   assign inst_o       = inst_q;
   assign is_en_o      = is_en_q;
   assign exec_start_o = exec_start_q;
   assign pc_o         = pc_q;
   assign retired_o    = retired_q;
   assign busy_o       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
`ifdef FETCH_TIMEOUT_EN
   assign fault_o      = fault_q;
`else
   assign fault_o      = 1'b0;
`endif

endmodule
